hit_judge: RTL
==============

// Module: hit_judge
// PURPOSE
//  Scoring stage between the NIOS keycode export and the note sprites / HEX display.
//  Decodes keycode into per-lane fret presses and judges each press against the
//    current note positions.
//  Reports hits and misses, clears judged notes, and keeps combo, multiplier and
//    BCD score for HexDriver.
// PARAMETERS
//  NUM_LANES   5    lanes 0..4 = green, red, yellow, blue, orange
//  Y_W         10   width of note Y coordinate (matches DrawY)
//  HIT_Y_TOP   400  first Y (inclusive) of hit window
//  HIT_Y_BOT   440  last Y (inclusive) of hit window; note_y > HIT_Y_BOT = passed
//  COMBO_MAX   99   combo saturation value
// PORTS
//  Clk          in   1             50 MHz system clock
//  Reset        in   1             synchronous, active-high
//  frame_clk    in   1             VGA_VS; rising edge = frame tick (async, 2-FF synced)
//  keycode      in   8             NIOS keycode; 0x00 = no key
//  note_active  in   NUM_LANES     lane has a live note
//  note_y       in   NUM_LANES*Y_W packed note Y positions, lane0 in LSBs
//  note_clear   out  NUM_LANES     1-cycle pulse: sprite must retire its note
//  hit_pulse    out  1             1-cycle pulse per judged hit
//  miss_pulse   out  1             1-cycle pulse per judged miss
//  combo        out  7             consecutive hits, binary, saturates at COMBO_MAX
//  multiplier   out  3             1..4
//  score_bcd    out  16            4 BCD digits, saturates at 9999
// BEHAVIOUR
//  Reset: all outputs 0 except multiplier=1; FSM -> IDLE; pending flags cleared.
//    Reset mid-operation aborts any judge/add in progress.
//  Keymap: 0x04->lane0, 0x16->lane1, 0x07->lane2, 0x09->lane3, 0x0A->lane4; other codes ignored.
//  Press event: registered keycode differs from previous value and the new value is mapped.
//    Holding a key = one event; release (0x00) is no event.
//  Tick: rising edge of synced frame_clk.
//    Sets pend_scan; the scan happens when the FSM is next in IDLE.
//  Pending press: at most one (pend_press plus lane).
//    A newer press while one is pending overwrites it.
//  FSM states:
//   IDLE   priority: pend_press -> JUDGE, else pend_scan -> SCAN (lane=0), else stay.
//   JUDGE  1 cycle.
//          hit if note_active[lane] && HIT_Y_TOP<=y<=HIT_Y_BOT: note_clear[lane], hit_pulse, -> ADD.
//          otherwise miss_pulse, no clear, -> IDLE.
//   SCAN   one lane per cycle, lane 0..4.
//          note_active && y>HIT_Y_BOT: note_clear[lane], miss_pulse.
//          After lane 4 -> IDLE, clear pend_scan.
//   ADD    adds 10 points multiplier times, one tens-digit BCD increment per cycle with ripple carry.
//          Then combo++ (saturating) -> IDLE.
//  Miss: combo <= 0 on the same cycle as miss_pulse.
//  Multiplier: 1+combo/10, capped at 4.
//    Recomputed combinationally from the registered combo.
//    ADD uses the value latched on JUDGE entry.
//  Latency: press edge on keycode -> hit/miss pulse exactly 3 cycles later
//    (register, detect, JUDGE) when the FSM is idle.
//  Score saturation: an increment that would exceed 9999 sets score to 9999.
//  Simultaneous press and tick: both are latched; the press is judged first.
//    The scan sees note_y values that are up to 1 frame newer; this is acceptable.
//  Every pulse output is high for exactly one cycle; note_clear has at most one bit set per cycle.
// STRUCTURE
//  guitar_pkg: lane_t enum, KEY_* keycode constants, HIT_Y_TOP/BOT defaults,
//    state_t enum {IDLE, JUDGE, SCAN, ADD}.
//  Sub-module bcd_sat_counter: 4-digit BCD, inc_tens pulse, saturating at 9999,
//    synchronous clear.
//  Top: sync/edge detect, keycode decode, FSM, combo/multiplier regs.
// TESTING
//  1 lane2 note_y=420 active; keycode 0x00->0x07
//    -> 3 cycles later hit_pulse, note_clear=5'b00100, score 0010, combo 1.
//  2 lane0 note_y=300 active; press 0x04
//    -> miss_pulse, note_clear=0, combo reset to 0 from 5, score unchanged.
//  3 lanes 1 and 3 note_y=450 active; one frame_clk rise
//    -> two miss_pulse cycles, note_clear 00010 then 01000.
//  4 preload combo 35; hit -> multiplier 4, score +40, combo 36.
//    Score 9990 with multiplier 2 -> score 9999.
//  5 press and frame_clk rise on the same cycle
//    -> JUDGE completes before SCAN; hold key 100 cycles -> only one event.
//  6 Reset asserted during ADD -> next cycle score 0000, combo 0, multiplier 1, no pulses.

Source files
------------

// File: rtl/hit_judge_pkg.sv
// rtl/hit_judge_pkg.sv - shared lane, keycode, state and geometry definitions for hit_judge
package hit_judge_pkg;
  localparam int NUM_LANES = 5;
  localparam int Y_W       = 10;

  localparam logic [Y_W-1:0] HIT_Y_TOP = Y_W'(400);
  localparam logic [Y_W-1:0] HIT_Y_BOT = Y_W'(440);
  localparam logic [6:0]     COMBO_MAX = 7'd99;

  localparam logic [7:0] KEY_GREEN  = 8'h04;
  localparam logic [7:0] KEY_RED    = 8'h16;
  localparam logic [7:0] KEY_YELLOW = 8'h07;
  localparam logic [7:0] KEY_BLUE   = 8'h09;
  localparam logic [7:0] KEY_ORANGE = 8'h0A;

  typedef enum logic [2:0] {
    LANE_GREEN, LANE_RED, LANE_YELLOW, LANE_BLUE, LANE_ORANGE
  } lane_t;

  typedef enum logic [1:0] {IDLE, JUDGE, SCAN, ADD} state_t;

  typedef struct packed {
    logic  valid;
    lane_t lane;
  } key_map_t;

  function automatic key_map_t decode_key(input logic [7:0] k);
    key_map_t m;
    m.valid = 1'b1;
    m.lane  = LANE_GREEN;
    case (k)
      KEY_GREEN:  m.lane = LANE_GREEN;
      KEY_RED:    m.lane = LANE_RED;
      KEY_YELLOW: m.lane = LANE_YELLOW;
      KEY_BLUE:   m.lane = LANE_BLUE;
      KEY_ORANGE: m.lane = LANE_ORANGE;
      default:    m.valid = 1'b0;
    endcase
    return m;
  endfunction

  // Equivalent to min(4, 1 + combo/10) without a divider.
  function automatic logic [2:0] mult_of(input logic [6:0] c);
    if (c >= 7'd30)      return 3'd4;
    else if (c >= 7'd20) return 3'd3;
    else if (c >= 7'd10) return 3'd2;
    else                 return 3'd1;
  endfunction

  function automatic logic [NUM_LANES-1:0] lane_mask(input lane_t l);
    return NUM_LANES'(1) << l;
  endfunction
endpackage

// File: rtl/hit_judge_if.sv
// rtl/hit_judge_if.sv - keycode/note inputs and scoring outputs of hit_judge
interface hit_judge_if;
  import hit_judge_pkg::*;

  logic [7:0]             i_keycode;
  logic [NUM_LANES-1:0]   i_note_active;
  logic [NUM_LANES*Y_W-1:0] i_note_y;
  logic [NUM_LANES-1:0]   o_note_clear;
  logic                   o_hit_pulse;
  logic                   o_miss_pulse;
  logic [6:0]             o_combo;
  logic [2:0]             o_multiplier;
  logic [15:0]            o_score_bcd;

  modport slave (
    input  i_keycode, i_note_active, i_note_y,
    output o_note_clear, o_hit_pulse, o_miss_pulse, o_combo, o_multiplier, o_score_bcd
  );

  modport master (
    output i_keycode, i_note_active, i_note_y,
    input  o_note_clear, o_hit_pulse, o_miss_pulse, o_combo, o_multiplier, o_score_bcd
  );
endinterface

// File: rtl/hit_judge_bcd_sat_counter.sv
// rtl/hit_judge_bcd_sat_counter.sv - 4-digit BCD score, +10 per pulse, saturating at 9999
module bcd_sat_counter (
  input  logic        i_clk,
  input  logic        i_clear,
  input  logic        i_inc_tens,
  output logic [15:0] o_bcd
);
  logic [3:0] r_ones, r_tens, r_hund, r_thou;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_ones <= 4'd0;
      r_tens <= 4'd0;
      r_hund <= 4'd0;
      r_thou <= 4'd0;
    end else if (i_inc_tens) begin
      // Anything at or above 9990 would overflow past 9999, so pin every digit to 9.
      if (r_thou == 4'd9 && r_hund == 4'd9 && r_tens == 4'd9) begin
        r_ones <= 4'd9;
        r_tens <= 4'd9;
        r_hund <= 4'd9;
        r_thou <= 4'd9;
      end else if (r_tens != 4'd9) begin
        r_tens <= r_tens + 4'd1;
      end else begin
        r_tens <= 4'd0;
        if (r_hund != 4'd9) begin
          r_hund <= r_hund + 4'd1;
        end else begin
          r_hund <= 4'd0;
          r_thou <= r_thou + 4'd1;
        end
      end
    end
  end

  assign o_bcd = {r_thou, r_hund, r_tens, r_ones};
endmodule

// File: rtl/hit_judge.sv
// rtl/hit_judge.sv - decodes fret presses, judges them against note positions, keeps combo and score
module hit_judge
  import hit_judge_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_frame_clk,
  hit_judge_if.slave  io_bus
);
  logic                 r_fc_s1, r_fc_s2, r_fc_s3;
  logic [7:0]           r_key, r_key_prev;
  logic                 r_pend_press, r_pend_scan;
  lane_t                r_pend_lane, r_lane;
  state_t               r_state;
  logic [2:0]           r_add_cnt;
  logic [6:0]           r_combo;
  logic [NUM_LANES-1:0] r_note_clear;
  logic                 r_hit, r_miss;

  key_map_t       w_map;
  logic           w_press, w_tick, w_active, w_in_window, w_passed, w_inc;
  logic [Y_W-1:0] w_y;
  logic [2:0]     w_mult;
  logic [15:0]    w_score;

  assign w_map       = decode_key(r_key);
  assign w_press     = (r_key != r_key_prev) && w_map.valid;
  assign w_tick      = r_fc_s2 & ~r_fc_s3;
  assign w_y         = io_bus.i_note_y[int'(r_lane) * Y_W +: Y_W];
  assign w_active    = io_bus.i_note_active[r_lane];
  assign w_in_window = (w_y >= HIT_Y_TOP) && (w_y <= HIT_Y_BOT);
  assign w_passed    = w_y > HIT_Y_BOT;
  assign w_mult      = mult_of(r_combo);
  assign w_inc       = (r_state == ADD);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fc_s1      <= 1'b0;
      r_fc_s2      <= 1'b0;
      r_fc_s3      <= 1'b0;
      r_key        <= 8'h00;
      r_key_prev   <= 8'h00;
      r_pend_press <= 1'b0;
      r_pend_scan  <= 1'b0;
      r_pend_lane  <= LANE_GREEN;
      r_lane       <= LANE_GREEN;
      r_state      <= IDLE;
      r_add_cnt    <= 3'd0;
      r_combo      <= 7'd0;
      r_note_clear <= '0;
      r_hit        <= 1'b0;
      r_miss       <= 1'b0;
    end else begin
      r_fc_s1      <= i_frame_clk;
      r_fc_s2      <= r_fc_s1;
      r_fc_s3      <= r_fc_s2;
      r_key        <= io_bus.i_keycode;
      r_key_prev   <= r_key;
      r_note_clear <= '0;
      r_hit        <= 1'b0;
      r_miss       <= 1'b0;

      if (w_press) begin
        r_pend_press <= 1'b1;
        r_pend_lane  <= w_map.lane;
      end

      case (r_state)
        IDLE: begin
          // A fresh press is taken straight from the detector so an idle FSM judges in 3 cycles.
          if (w_press || r_pend_press) begin
            r_state      <= JUDGE;
            r_lane       <= w_press ? w_map.lane : r_pend_lane;
            r_pend_press <= 1'b0;
            r_add_cnt    <= w_mult;
          end else if (r_pend_scan) begin
            r_state <= SCAN;
            r_lane  <= LANE_GREEN;
          end
        end
        JUDGE: begin
          if (w_active && w_in_window) begin
            r_note_clear <= lane_mask(r_lane);
            r_hit        <= 1'b1;
            r_state      <= ADD;
          end else begin
            r_miss  <= 1'b1;
            r_combo <= 7'd0;
            r_state <= IDLE;
          end
        end
        SCAN: begin
          if (w_active && w_passed) begin
            r_note_clear <= lane_mask(r_lane);
            r_miss       <= 1'b1;
            r_combo      <= 7'd0;
          end
          if (r_lane == LANE_ORANGE) begin
            r_state     <= IDLE;
            r_pend_scan <= 1'b0;
          end else begin
            r_lane <= lane_t'(r_lane + 3'd1);
          end
        end
        ADD: begin
          if (r_add_cnt <= 3'd1) begin
            r_state <= IDLE;
            if (r_combo != COMBO_MAX) r_combo <= r_combo + 7'd1;
          end else begin
            r_add_cnt <= r_add_cnt - 3'd1;
          end
        end
        default: r_state <= IDLE;
      endcase

      // A tick landing on the final scan cycle must not be lost.
      if (w_tick) r_pend_scan <= 1'b1;
    end
  end

  bcd_sat_counter u_score (
    .i_clk      (i_clk),
    .i_clear    (i_reset),
    .i_inc_tens (w_inc),
    .o_bcd      (w_score)
  );

  assign io_bus.o_note_clear = r_note_clear;
  assign io_bus.o_hit_pulse  = r_hit;
  assign io_bus.o_miss_pulse = r_miss;
  assign io_bus.o_combo      = r_combo;
  assign io_bus.o_multiplier = w_mult;
  assign io_bus.o_score_bcd  = w_score;
endmodule
